dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory (32-bit words, 10-bit byte_address, combinational read, write on posedge) between two requesters.
- Port 0 is the core load/store path; port 1 is a loader/DMA/debug path.
- Arbitrates each cycle, drives the memory port, and returns a registered one-cycle response to the granted requester.
- Fixed priority to port 0 with a starvation guard for port 1.

Parameters:
ADDR_W, 10, memory address width (matches memory byte_address)
DATA_W, 32, data width
STARVE_LIMIT, 4, consecutive denied cycles of a valid port-1 request before port 1 is forced a grant (legal range 1..15)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
req0_valid  input  1  port 0 request present
req0_ready  output  1  port 0 request accepted this cycle
req0_we  input  1  port 0 write (1) / read (0)
req0_addr  input  ADDR_W  port 0 address
req0_wdata  input  DATA_W  port 0 write data
rsp0_valid  output  1  port 0 response pulse
rsp0_rdata  output  DATA_W  port 0 read data
req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata: same as port 0, for port 1
mem_addr  output  ADDR_W  to memory byte_address
mem_we  output  1  to memory write_enable
mem_wdata  output  DATA_W  to memory write_data
mem_rdata  input  DATA_W  from memory read_data

Behaviour:
- Grant logic is combinational from the current valids and starvation state. reqN_ready = grantN. At most one grant per cycle.
- Arbitration:
  - Only port 0 valid: grant 0.
  - Only port 1 valid: grant 1.
  - Both valid: grant 0, unless starve_cnt == STARVE_LIMIT, in which case grant 1.
  - Neither valid: no grant.
- Memory drive:
  - Granted port's addr/we/wdata are muxed onto mem_*; mem_we = granted we.
  - With no grant: mem_we=0, mem_addr=0, mem_wdata=0.
  - A write is committed at the same clk edge as the accept.
- starve_cnt (4 bits):
  - Increments when req1_valid=1 and grant1=0, saturating at STARVE_LIMIT.
  - Clears to 0 when grant1=1 or req1_valid=0.
- Response, latency 1 cycle:
  - On the edge after an accept, rspN_valid=1 for exactly one cycle.
  - rspN_rdata = mem_rdata sampled at the accept edge for reads; 0 for writes.
  - rspN_rdata holds its value while rspN_valid=0.
- Back-to-back accepts on one port give consecutive rsp pulses. Both ports never pulse rsp in the same cycle.
- Read-after-write, same address, consecutive cycles: the read returns the new data, because the write is committed before the read is issued.
- Requester holds addr/we/wdata stable while valid && !ready. The arbiter does not check this.
- Reset (asynchronous, any time):
  - starve_cnt=0, rsp0_valid=0, rsp1_valid=0, rsp0_rdata=0, rsp1_rdata=0, rr_last=0.
  - An in-flight response is dropped.
  - During reset, readies and mem_we are 0 (grants gated by reset).
- Out-of-range address: no check; the memory decides.

Optional Feature:
DMEM_ARB_RR_EN:
- Defined:
  - On contention, grant goes to the port not granted most recently. rr_last is a 1-bit register updated on every grant, reset 0 (so port 1 wins the first contention).
  - starve_cnt and STARVE_LIMIT are unused; the counter is removed.
- Undefined: fixed priority with starvation guard as above.

Test Plan:
1. Port 0 writes 0xDEADBEEF to addr 5, then reads addr 5 the next cycle -> req0_ready=1 both cycles; rsp0_valid pulses twice; second rsp0_rdata=0xDEADBEEF; first = 0.
2. Port 1 alone reads addr 3 (preloaded 0x12345678) -> req1_ready=1 same cycle; rsp1_valid=1 next cycle with 0x12345678; rsp0_valid stays 0.
3. Both valid continuously, STARVE_LIMIT=4 (macro undefined) -> grants 0,0,0,0,1,0,0,0,0,1...; starve_cnt sequence 1,2,3,4,0.
4. Both valid continuously with DMEM_ARB_RR_EN -> grants alternate 1,0,1,0,...
5. Port 0 read accepted, reset asserted asynchronously before the next edge -> rsp0_valid stays 0; all registered outputs 0 immediately; after release, a port-1 write to addr 7 completes normally.
6. Neither valid for 3 cycles -> mem_we=0, mem_addr=0, readies 0, no rsp pulses; memory contents unchanged.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between two requesters.
// Port 0 (core load/store) has fixed priority over port 1 (loader/DMA/debug),
// with a starvation guard that forces a port-1 grant after STARVE_LIMIT
// consecutive denied cycles. Responses are registered, one cycle after accept.
// Optional macro DMEM_ARB_RR_EN: contention is resolved round-robin instead,
// and the starvation counter is removed.
module dmem_arbiter #(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    // port 0: core load/store path
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    // port 1: loader / DMA / debug path
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    // memory port
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic              w_pick1;
    logic              w_grant0;
    logic              w_grant1;

    logic              r_rsp0_valid;
    logic [DATA_W-1:0] r_rsp0_rdata;
    logic              r_rsp1_valid;
    logic [DATA_W-1:0] r_rsp1_rdata;

`ifdef DMEM_ARB_RR_EN
    // Index of the most recently granted port; 0 after reset so port 1 wins first.
    logic r_rr_last;

    assign w_pick1 = ~r_rr_last;

    // Remember which port was granted last.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_last <= 1'b0;
        end else if (w_grant0 || w_grant1) begin
            r_rr_last <= w_grant1;
        end
    end
`else
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_starve_cnt;

    assign w_pick1 = (r_starve_cnt == LIMIT_C);

    // Count consecutive cycles port 1 waits; saturate at the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (req1_valid && !w_grant1) begin
            if (r_starve_cnt != LIMIT_C) begin
                r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end
        end else begin
            r_starve_cnt <= '0;
        end
    end
`endif

    // Grant selection; at most one grant, none while reset is asserted.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (!reset) begin
            if (req0_valid && req1_valid) begin
                w_grant1 = w_pick1;
                w_grant0 = ~w_pick1;
            end else begin
                w_grant0 = req0_valid;
                w_grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    // Mux the granted request onto the memory port; idle drives zeros.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (w_grant0) begin
            mem_addr  = req0_addr;
            mem_we    = req0_we;
            mem_wdata = req0_wdata;
        end else if (w_grant1) begin
            mem_addr  = req1_addr;
            mem_we    = req1_we;
            mem_wdata = req1_wdata;
        end
    end

    // One-cycle response; read data captured at accept, writes return zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp0_valid <= 1'b0;
            r_rsp0_rdata <= '0;
            r_rsp1_valid <= 1'b0;
            r_rsp1_rdata <= '0;
        end else begin
            r_rsp0_valid <= w_grant0;
            r_rsp1_valid <= w_grant1;
            if (w_grant0) begin
                r_rsp0_rdata <= req0_we ? '0 : mem_rdata;
            end
            if (w_grant1) begin
                r_rsp1_rdata <= req1_we ? '0 : mem_rdata;
            end
        end
    end

    assign rsp0_valid = r_rsp0_valid;
    assign rsp0_rdata = r_rsp0_rdata;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp1_rdata = r_rsp1_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, reset corner case, and
// randomized traffic against a rule-level reference model with shadow memory.
module tb_dmem_arbiter;

    localparam int unsigned ADDR_W       = 10;
    localparam int unsigned DATA_W       = 32;
    localparam int          STARVE_LIMIT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              req0_valid, req0_ready, req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;
    logic              req1_valid, req1_ready, req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    typedef struct {
        logic        v0;
        logic        we0;
        logic [9:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic        we1;
        logic [9:0]  a1;
        logic [31:0] d1;
        int          exp_g;   // -1 none, 0 or 1
        logic [31:0] exp_rd;  // response data of the granted port
    } vec_t;

    vec_t tbl [16];

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int          m_denied;
    int          m_last;
    logic [31:0] m_rd0, m_rd1;
    logic        m_rv0, m_rv1;
    logic [31:0] ref_mem [0:255];

    // memory environment: combinational read, write on rising edge
    logic [31:0] mem_arr [0:255];

    dmem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem_arr[mem_addr[9:2]] <= mem_wdata;
    end
    assign mem_rdata = mem_arr[mem_addr[9:2]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic v0, input logic we0, input logic [9:0] a0,
                                input logic [31:0] d0, input logic v1, input logic we1,
                                input logic [9:0] a1, input logic [31:0] d1,
                                input int g, input logic [31:0] rd);
        vec_t v;
        v.v0 = v0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.we1 = we1; v.a1 = a1; v.d1 = d1;
        v.exp_g = g; v.exp_rd = rd;
        return v;
    endfunction

    // Which port the rules say is granted this cycle (-1: none).
    function automatic int model_grant(input bit rst, input logic v0, input logic v1);
        if (rst) return -1;
        if (v0 && v1) begin
`ifdef DMEM_ARB_RR_EN
            return 1 - m_last;
`else
            return (m_denied >= STARVE_LIMIT) ? 1 : 0;
`endif
        end
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_denied = 0; m_last = 0;
        m_rd0 = '0; m_rd1 = '0; m_rv0 = 1'b0; m_rv1 = 1'b0;
    endtask

    // One clock cycle: entered and left at posedge+1.
    task automatic run_cycle(input vec_t v, input bit rst, input bit use_tbl);
        int g;
        reset = rst;
        req0_valid = v.v0; req0_we = v.we0; req0_addr = v.a0; req0_wdata = v.d0;
        req1_valid = v.v1; req1_we = v.we1; req1_addr = v.a1; req1_wdata = v.d1;
        g = model_grant(rst, v.v0, v.v1);
        #3;
        check("req0_ready", 32'(req0_ready), 32'(g == 0));
        check("req1_ready", 32'(req1_ready), 32'(g == 1));
        check("mem_we", 32'(mem_we), (g == 0) ? 32'(v.we0) : (g == 1) ? 32'(v.we1) : 32'd0);
        check("mem_addr", 32'(mem_addr), (g == 0) ? 32'(v.a0) : (g == 1) ? 32'(v.a1) : 32'd0);
        check("mem_wdata", mem_wdata, (g == 0) ? v.d0 : (g == 1) ? v.d1 : 32'd0);
        if (use_tbl)
            check("tbl_grant", 32'({req1_ready, req0_ready}),
                  (v.exp_g == 0) ? 32'd1 : (v.exp_g == 1) ? 32'd2 : 32'd0);
        if (rst) begin
            model_reset();
        end else begin
            m_rv0 = (g == 0);
            m_rv1 = (g == 1);
            if (g == 0) m_rd0 = v.we0 ? 32'd0 : ref_mem[v.a0[9:2]];
            if (g == 1) m_rd1 = v.we1 ? 32'd0 : ref_mem[v.a1[9:2]];
            if (g == 0 && v.we0) ref_mem[v.a0[9:2]] = v.d0;
            if (g == 1 && v.we1) ref_mem[v.a1[9:2]] = v.d1;
            if (g >= 0) m_last = g;
            if (v.v1 && g != 1)
                m_denied = (m_denied < STARVE_LIMIT) ? m_denied + 1 : STARVE_LIMIT;
            else
                m_denied = 0;
        end
        @(posedge clk);
        #1;
        check("rsp0_valid", 32'(rsp0_valid), 32'(m_rv0));
        check("rsp0_rdata", rsp0_rdata, m_rd0);
        check("rsp1_valid", 32'(rsp1_valid), 32'(m_rv1));
        check("rsp1_rdata", rsp1_rdata, m_rd1);
        if (use_tbl && v.exp_g == 0) check("tbl_rdata0", rsp0_rdata, v.exp_rd);
        if (use_tbl && v.exp_g == 1) check("tbl_rdata1", rsp1_rdata, v.exp_rd);
    endtask

    initial begin
        vec_t v;
        int   g;
        int   diffs;

        for (int i = 0; i < 256; i++) begin
            mem_arr[i] <= 32'd0;
            ref_mem[i] = 32'd0;
        end
        mem_arr[0] <= 32'h1234_5678;
        ref_mem[0] = 32'h1234_5678;

        // reset with both requests pending: no grants, no memory write
        reset = 1'b1;
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 10'd5; req0_wdata = 32'hFFFF_FFFF;
        req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 10'd3; req1_wdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req0_ready", 32'(req0_ready), 32'd0);
        check("rst_req1_ready", 32'(req1_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
        check("rst_rsp0_rdata", rsp0_rdata, 32'd0);
        check("rst_rsp1_rdata", rsp1_rdata, 32'd0);
        model_reset();

        // directed table
        tbl[0] = mk(1, 1, 10'd5, 32'hDEAD_BEEF, 0, 0, 10'd0, 32'd0, 0, 32'd0);
        tbl[1] = mk(1, 0, 10'd5, 32'd0,        0, 0, 10'd0, 32'd0, 0, 32'hDEAD_BEEF);
        tbl[2] = mk(0, 0, 10'd0, 32'd0,        1, 0, 10'd3, 32'd0, 1, 32'h1234_5678);
        for (int i = 0; i < 10; i++) begin
`ifdef DMEM_ARB_RR_EN
            g = (i % 2 == 0) ? 0 : 1;
`else
            g = (i == 4 || i == 9) ? 1 : 0;
`endif
            tbl[3 + i] = mk(1, 0, 10'd5, 32'd0, 1, 0, 10'd3, 32'd0, g,
                            (g == 0) ? 32'hDEAD_BEEF : 32'h1234_5678);
        end
        for (int i = 13; i < 16; i++)
            tbl[i] = mk(0, 0, 10'd0, 32'd0, 0, 0, 10'd0, 32'd0, -1, 32'd0);

        reset = 1'b0;
        for (int i = 0; i < 16; i++) run_cycle(tbl[i], 1'b0, 1'b1);

        // reset lands between a port-0 accept and its response edge
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 10'd5; req0_wdata = 32'd0;
        req1_valid = 1'b0;
        #1;
        check("pre_rst_ready0", 32'(req0_ready), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("async_ready0", 32'(req0_ready), 32'd0);
        check("async_mem_we", 32'(mem_we), 32'd0);
        check("async_rsp0_rdata", rsp0_rdata, 32'd0);
        check("async_rsp1_rdata", rsp1_rdata, 32'd0);
        check("async_rsp1_valid", 32'(rsp1_valid), 32'd0);
        @(posedge clk);
        #1;
        check("dropped_rsp0", 32'(rsp0_valid), 32'd0);
        req0_valid = 1'b0;
        model_reset();
        run_cycle(mk(0, 0, 10'd0, 32'd0, 1, 1, 10'd7, 32'hCAFE_F00D, 1, 32'd0), 1'b0, 1'b1);
        run_cycle(mk(0, 0, 10'd0, 32'd0, 1, 0, 10'd7, 32'd0, 1, 32'hCAFE_F00D), 1'b0, 1'b1);

        // randomized traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            v.v0 = 1'($urandom_range(0, 1));  v.we0 = 1'($urandom_range(0, 1));
            v.a0 = 10'($urandom_range(0, 31)); v.d0 = $urandom;
            v.v1 = 1'($urandom_range(0, 1));  v.we1 = 1'($urandom_range(0, 1));
            v.a1 = 10'($urandom_range(0, 31)); v.d1 = $urandom;
            v.exp_g = -1; v.exp_rd = 32'd0;
            run_cycle(v, ($urandom_range(0, 39) == 0), 1'b0);
        end
        run_cycle(mk(0, 0, 10'd0, 32'd0, 0, 0, 10'd0, 32'd0, -1, 32'd0), 1'b0, 1'b0);

        diffs = 0;
        for (int i = 0; i < 256; i++)
            if (mem_arr[i] !== ref_mem[i]) diffs++;
        check("mem_contents", 32'(diffs), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
